calc_display_ctrl: RTL and testbench

// Receiving end of the calc display interface (status/data/pos). Captures digits streamed by calc
// (one digit per cycle, pos 0 = least significant), commits a full frame into a visible buffer
// and drives eight time-multiplexed, active-low seven-segment displays. Shows "Erro" on status ERRO.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/seg7_decoder.sv | 38 +++
 rtl/calc_display_ctrl.sv | 107 ++++++++++
 tb/tb_calc_display_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: encodings shared between calc and its display receiver.
// Status codes, blank digit code and active-low seven-segment glyphs {g,f,e,d,c,b,a}.
package calc_pkg;

   localparam logic [1:0] ST_ERRO       = 2'b00;
   localparam logic [1:0] ST_OCUPADO    = 2'b01;
   localparam logic [1:0] ST_PRONTO     = 2'b10;
   localparam logic [1:0] ST_IMPRIMINDO = 2'b11;

   localparam logic [3:0] BLANK = 4'hF;

   localparam logic [6:0] GLYPH_0     = 7'b1000000;
   localparam logic [6:0] GLYPH_1     = 7'b1111001;
   localparam logic [6:0] GLYPH_2     = 7'b0100100;
   localparam logic [6:0] GLYPH_3     = 7'b0110000;
   localparam logic [6:0] GLYPH_4     = 7'b0011001;
   localparam logic [6:0] GLYPH_5     = 7'b0010010;
   localparam logic [6:0] GLYPH_6     = 7'b0000010;
   localparam logic [6:0] GLYPH_7     = 7'b1111000;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;
   localparam logic [6:0] GLYPH_9     = 7'b0010000;
   localparam logic [6:0] GLYPH_E     = 7'b0000110;
   localparam logic [6:0] GLYPH_R     = 7'b0101111;
   localparam logic [6:0] GLYPH_O     = 7'b0100011;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational digit/letter to active-low segment decoder.
// Ports: code (digit 0..9, else blank; with err, display index 0..3 -> o,r,r,E), err, segs.
module seg7_decoder
   import calc_pkg::*;
(
   input  logic [3:0] code,
   input  logic       err,
   output logic [6:0] segs
);

   always_comb begin
      segs = GLYPH_BLANK;
      if (err) begin
         case (code)
            4'd3:    segs = GLYPH_E;
            4'd2:    segs = GLYPH_R;
            4'd1:    segs = GLYPH_R;
            4'd0:    segs = GLYPH_O;
            default: segs = GLYPH_BLANK;
         endcase
      end else begin
         case (code)
            4'd0:    segs = GLYPH_0;
            4'd1:    segs = GLYPH_1;
            4'd2:    segs = GLYPH_2;
            4'd3:    segs = GLYPH_3;
            4'd4:    segs = GLYPH_4;
            4'd5:    segs = GLYPH_5;
            4'd6:    segs = GLYPH_6;
            4'd7:    segs = GLYPH_7;
            4'd8:    segs = GLYPH_8;
            4'd9:    segs = GLYPH_9;
            default: segs = GLYPH_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/calc_display_ctrl.sv
// calc_display_ctrl: captures digit frames from calc and scans them onto 7-seg displays.
// Ports: clock, reset (async high), status/data/pos from calc; an, seg, dp active-low outputs.
module calc_display_ctrl
   import calc_pkg::*;
#(
   parameter int N_DIGITS = 8,
   parameter int SCAN_DIV = 50000,
   parameter int LZ_BLANK = 1
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] status,
   input  logic [3:0] data,
   input  logic [3:0] pos,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

   logic [3:0]    shadow  [N_DIGITS];
   logic [3:0]    visible [N_DIGITS];
   logic          err_flag;
   logic [PW-1:0] presc;
   logic [IW-1:0] idx;
   logic [IW-1:0] nidx;
   logic          wrap;
   logic          pos_in;
   logic          pos_end;
   logic [3:0]    entry;
   logic [3:0]    code;
   logic          upper_zero;
   logic [6:0]    glyph;

   assign pos_in  = 32'(pos) < 32'(N_DIGITS);
   assign pos_end = 32'(pos) == 32'(N_DIGITS);
   assign dp      = 1'b1;

   // Frame capture: shadow fills digit by digit, visible only changes on commit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_flag <= 1'b0;
         for (int i = 0; i < N_DIGITS; i++) begin
            shadow[i]  <= BLANK;
            visible[i] <= BLANK;
         end
      end else if (err_flag || status == ST_ERRO) begin
         err_flag <= 1'b1;
      end else if (status == ST_OCUPADO) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            shadow[i]  <= BLANK;
            visible[i] <= BLANK;
         end
      end else if (status == ST_IMPRIMINDO && pos_in) begin
         shadow[pos[IW-1:0]] <= (data > 4'd9) ? BLANK : data;
      end else if (status == ST_IMPRIMINDO && pos_end) begin
         for (int i = 0; i < N_DIGITS; i++)
            visible[i] <= shadow[i];
      end
   end

   assign wrap = presc == PRE_MAX;
   assign nidx = (idx == IDX_MAX) ? '0 : idx + 1'b1;

   // Glyph for the digit about to be lit. In error mode the index itself
   // selects the letter; otherwise leading zeros may be suppressed.
   always_comb begin
      entry      = visible[nidx];
      upper_zero = 1'b1;
      for (int j = 0; j < N_DIGITS; j++)
         if (j > int'(nidx) && visible[j] != 4'd0 && visible[j] != BLANK)
            upper_zero = 1'b0;
      code = entry;
      if (err_flag)
         code = 4'(nidx);
      else if (LZ_BLANK != 0 && entry == 4'd0 && nidx != '0 && upper_zero)
         code = BLANK;
   end

   seg7_decoder u_dec (
      .code (code),
      .err  (err_flag),
      .segs (glyph)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc <= '0;
         idx   <= '0;
         an    <= 8'hFF;
         seg   <= GLYPH_BLANK;
      end else if (wrap) begin
         presc <= '0;
         idx   <= nidx;
         an    <= ~(8'(1) << nidx);
         seg   <= glyph;
      end else begin
         presc <= presc + 1'b1;
      end
   end

endmodule

// File: tb/tb_calc_display_ctrl.sv
// tb_calc_display_ctrl: scoreboard bench with a frame-level reference model.
// Stimulus pushes expected full-display glyph sets; a monitor checks each scan step.
module tb_calc_display_ctrl;

   localparam int N  = 8;
   localparam int SD = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] status = 2'b10;
   logic [3:0] data = 4'd0;
   logic [3:0] pos = 4'd0;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;

   calc_display_ctrl #(
      .N_DIGITS (N),
      .SCAN_DIV (SD),
      .LZ_BLANK (1)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .status (status),
      .data   (data),
      .pos    (pos),
      .an     (an),
      .seg    (seg),
      .dp     (dp)
   );

   always #5 clock = ~clock;

   int total  = 0;
   int passed = 0;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got == want) passed++;
      else $display("FAIL %s got=%h want=%h", name, got, want);
   endtask

   // Reference model: frame contents as plain arrays.
   logic [3:0] m_sh  [N];
   logic [3:0] m_vis [N];
   bit         m_err;

   function automatic logic [6:0] glyph_of(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [7*N-1:0] expected();
      logic [7*N-1:0] r;
      logic [6:0] g;
      int msd;
      msd = -1;
      for (int j = 0; j < N; j++)
         if (m_vis[j] >= 4'd1 && m_vis[j] <= 4'd9) msd = j;
      for (int i = 0; i < N; i++) begin
         if (m_err) begin
            if (i == 3) g = 7'b0000110;
            else if (i == 2 || i == 1) g = 7'b0101111;
            else if (i == 0) g = 7'b0100011;
            else g = 7'b1111111;
         end else if (m_vis[i] == 4'hF) g = 7'b1111111;
         else if (m_vis[i] == 4'd0 && i > 0 && i > msd) g = 7'b1111111;
         else g = glyph_of(m_vis[i]);
         r[7*i +: 7] = g;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_err = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_sh[i]  = 4'hF;
         m_vis[i] = 4'hF;
      end
   endtask

   task automatic apply(input logic [1:0] st, input logic [3:0] d, input logic [3:0] p);
      if (m_err || st == 2'b00) m_err = 1'b1;
      else if (st == 2'b01) begin
         for (int i = 0; i < N; i++) begin
            m_sh[i]  = 4'hF;
            m_vis[i] = 4'hF;
         end
      end else if (st == 2'b11 && int'(p) < N) m_sh[p] = (d > 4'd9) ? 4'hF : d;
      else if (st == 2'b11 && int'(p) == N) begin
         for (int i = 0; i < N; i++) m_vis[i] = m_sh[i];
      end
   endtask

   // Scoreboard
   logic [7*N-1:0] expq[$];
   logic [7*N-1:0] cur;
   int             ck_left = 0;
   logic [7:0]     last_an = 8'hFF;
   int             cyc = 0;
   int             last_ev = 0;
   int             prev_i = 0;
   int             mi;
   int             ones;

   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         if (!reset && an !== last_an && an !== 8'hFF) begin
            if (ck_left == 0 && expq.size() > 0) begin
               cur = expq.pop_front();
               ck_left = N;
            end
            if (ck_left > 0) begin
               mi = -1;
               ones = 0;
               for (int b = 0; b < 8; b++)
                  if (an[b] == 1'b0) begin
                     ones++;
                     mi = b;
                  end
               check("an_onehot", ones, 1);
               if (mi >= 0)
                  check($sformatf("seg_digit%0d", mi), int'(seg), int'(cur[7*mi +: 7]));
               check("dp_off", int'(dp), 1);
               if (ck_left < N) begin
                  check("scan_gap", cyc - last_ev, SD);
                  check("scan_order", mi, (prev_i + 1) % N);
               end
               prev_i = mi;
               ck_left--;
            end
            last_ev = cyc;
         end
         last_an = an;
      end
   end

   task automatic op(input logic [1:0] st, input logic [3:0] d, input logic [3:0] p);
      @(negedge clock);
      status = st;
      data   = d;
      pos    = p;
      apply(st, d, p);
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while ((expq.size() != 0 || ck_left != 0) && k < 4*N*SD) begin
         @(negedge clock);
         k++;
      end
      if (expq.size() != 0 || ck_left != 0) begin
         total++;
         $display("FAIL scan_timeout got=%0d cycles want<%0d", k, 4*N*SD);
         expq.delete();
         ck_left = 0;
      end
   endtask

   task automatic idle_push();
      @(negedge clock);
      status = 2'b10;
      repeat (2) @(negedge clock);
      expq.push_back(expected());
      wait_done();
   endtask

   task automatic reset_seq();
      int k;
      #2;
      reset = 1'b1;
      #1;
      check("rst_an", int'(an), 8'hFF);
      check("rst_seg", int'(seg), 7'h7F);
      check("rst_dp", int'(dp), 1);
      model_reset();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      k = 0;
      while (an === 8'hFF && k < 3*SD) begin
         @(negedge clock);
         k++;
      end
      check("first_an", int'(an), 8'hFD);
      check("first_wrap_cycles", k, SD);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   int n;
   int r;
   logic [1:0] st;
   logic [3:0] d;
   logic [3:0] p;

   initial begin
      reset_seq();
      idle_push();

      for (int i = 0; i < N; i++) op(2'b11, (i < 3) ? 4'(3 - i) : 4'd0, 4'(i));
      op(2'b11, 4'd0, 4'd8);
      idle_push();

      for (int i = 0; i < 4; i++) op(2'b11, 4'(i + 5), 4'(i));
      idle_push();
      op(2'b11, 4'd0, 4'd8);
      idle_push();

      op(2'b11, 4'hC, 4'd1);
      op(2'b11, 4'd0, 4'd8);
      idle_push();

      op(2'b11, 4'd7, 4'd9);
      op(2'b11, 4'd7, 4'd15);
      op(2'b11, 4'd0, 4'd8);
      idle_push();

      for (int i = 0; i < N; i++) op(2'b11, (i < 3) ? 4'(i + 1) : 4'd0, 4'(i));
      op(2'b11, 4'd0, 4'd8);
      idle_push();
      op(2'b01, 4'd0, 4'd0);
      idle_push();

      repeat (12) begin
         n = $urandom_range(1, 12);
         repeat (n) begin
            r  = $urandom_range(0, 9);
            st = (r < 7) ? 2'b11 : ((r < 9) ? 2'b10 : 2'b01);
            p  = 4'($urandom_range(0, 10));
            d  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            op(st, d, p);
         end
         if ($urandom_range(0, 3) != 0) op(2'b11, 4'd0, 4'd8);
         idle_push();
      end

      repeat (5) @(negedge clock);
      reset_seq();
      idle_push();

      op(2'b00, 4'd0, 4'd0);
      for (int i = 0; i < N; i++) op(2'b11, 4'(i + 1), 4'(i));
      op(2'b11, 4'hC, 4'd0);
      op(2'b11, 4'd0, 4'd8);
      idle_push();
      op(2'b01, 4'd0, 4'd0);
      idle_push();

      reset_seq();
      idle_push();
      op(2'b11, 4'hC, 4'd0);
      op(2'b11, 4'd5, 4'd1);
      op(2'b11, 4'd0, 4'd8);
      idle_push();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
